mmio_bridge: RTL and testbench

Data-side address decoder between the single-cycle core's memory port (ALUResult / WriteData / MemWrite / ReadData) and the data RAM plus on-chip game peripherals. RAM accesses pass through; the I/O window holds LED output, synchronised switch and button inputs, a free-running 32-bit LFSR random source, and a compare timer. Reads are combinational so the core still completes loads in one cycle; all register updates happen on the rising clock edge.

---
 rtl/gt_mmio_pkg.sv | 27 ++
 rtl/mmio_bridge_if.sv | 16 +
 rtl/btn_sync_edge.sv | 39 +++
 rtl/mmio_bridge.sv | 153 +++++++++++++++
 tb/tb_mmio_bridge.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gt_mmio_pkg.sv
// Shared definitions for the data-side MMIO bridge: register map, CTRL bit
// positions and the RNG feedback function.
package gt_mmio_pkg;

  // I/O register byte addresses (word aligned).
  localparam logic [31:0] ADDR_LED     = 32'h0000_1000;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_1004;
  localparam logic [31:0] ADDR_BTN_CLR = 32'h0000_1008;
  localparam logic [31:0] ADDR_RNG     = 32'h0000_100C;
  localparam logic [31:0] ADDR_COUNT   = 32'h0000_1010;
  localparam logic [31:0] ADDR_CMP     = 32'h0000_1014;
  localparam logic [31:0] ADDR_CTRL    = 32'h0000_1018;

  // Timer CTRL bit indices.
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_EXP  = 2;

  // Galois feedback taps of the 32-bit RNG.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // One right-shift step of the Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// Core data-memory port as seen by the bridge. The master side is the rest of
// the system: the datapath drives address/data/strobe and the data RAM
// returns its read word; the bridge returns load data and the RAM write enable.
interface mmio_bridge_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] rdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  modport master (output mem_addr, mem_wdata, mem_we, ram_rdata,
                  input  rdata, ram_we);
  modport slave  (input  mem_addr, mem_wdata, mem_we, ram_rdata,
                  output rdata, ram_we);
endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronisers for the asynchronous buttons and switches, plus a
// rising-edge pulse on each synchronised button.
module btn_sync_edge #(
  parameter int N_BTN = 4,
  parameter int N_SW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  input  logic [N_SW-1:0]  sw_i,
  output logic [N_BTN-1:0] btn_rise_o,
  output logic [N_SW-1:0]  sw_sync_o
);

  logic [N_BTN-1:0] btn_meta_q, btn_sync_q, btn_prev_q;
  logic [N_SW-1:0]  sw_meta_q, sw_sync_q;

  // Synchroniser chains; btn_prev_q remembers last cycle's synchronised level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      // NOTE: non-blocking so each stage samples the previous stage's pre-edge value.
      btn_meta_q <= btn_i;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      sw_meta_q  <= sw_i;
      sw_sync_q  <= sw_meta_q;
    end
  end

  assign btn_rise_o = btn_sync_q & ~btn_prev_q;
  assign sw_sync_o  = sw_sync_q;

endmodule

// File: rtl/mmio_bridge.sv
// Data-side address decoder: RAM passthrough below 4*RAM_WORDS, an I/O window
// at 0x1000-0x101C (LED, switch/button status, RNG, compare timer), zero
// elsewhere. Loads are combinational; all register updates on the rising edge.
module mmio_bridge
  import gt_mmio_pkg::*;
#(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2024,
  parameter int          N_BTN     = 4,
  parameter int          N_SW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  mmio_bridge_if.slave     bus,
  input  logic [N_SW-1:0]  sw_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic [7:0]       led_o,
  output logic             timer_irq
);

  logic [31:0] addr_w;
  logic        is_ram, wr_io;
  logic        wr_led, wr_clr, wr_rng, wr_cmp, wr_ctrl;
  logic [N_BTN-1:0] btn_rise;
  logic [N_SW-1:0]  sw_sync;
  logic [31:0] status_w;
  logic        hit, run;
  logic        unused_addr_lo;

  logic [7:0]       led_q, led_d;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      cmp_q, cmp_d;
  logic             en_q, en_d, auto_q, auto_d, exp_q, exp_d;
  // Set after a one-shot match so COUNT resting on CMP does not re-match
  // once EXPIRED is cleared; lets the counter resume past CMP.
  logic             held_q, held_d;

  btn_sync_edge #(.N_BTN(N_BTN), .N_SW(N_SW)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .btn_i     (btn_i),
    .sw_i      (sw_i),
    .btn_rise_o(btn_rise),
    .sw_sync_o (sw_sync)
  );

  // Byte offset bits carry no information for word registers.
  assign unused_addr_lo = ^bus.mem_addr[1:0];

  assign addr_w     = {bus.mem_addr[31:2], 2'b00};
  assign is_ram     = bus.mem_addr[31:2] < 30'(RAM_WORDS);
  assign bus.ram_we = bus.mem_we & is_ram;
  assign wr_io      = bus.mem_we & ~is_ram;
  assign wr_led     = wr_io && (addr_w == ADDR_LED);
  assign wr_clr     = wr_io && (addr_w == ADDR_BTN_CLR);
  assign wr_rng     = wr_io && (addr_w == ADDR_RNG);
  assign wr_cmp     = wr_io && (addr_w == ADDR_CMP);
  assign wr_ctrl    = wr_io && (addr_w == ADDR_CTRL);

  assign hit = en_q && (count_q == cmp_q) && !held_q;
  assign run = en_q && !(exp_q && !auto_q);

  // Next-state for every I/O register.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    led_d   = led_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    auto_d  = auto_q;
    exp_d   = exp_q;
    count_d = count_q;
    held_d  = held_q;

    if (wr_led) led_d = bus.mem_wdata[7:0];

    // A new button edge wins over a coincident clear.
    pend_d = (pend_q & ~(wr_clr ? bus.mem_wdata[N_BTN-1:0] : '0)) | btn_rise;

    if (wr_rng) lfsr_d = (bus.mem_wdata == 32'h0) ? LFSR_SEED : bus.mem_wdata;
    else        lfsr_d = lfsr_next(lfsr_q);

    if (wr_cmp) cmp_d = bus.mem_wdata;
    if (wr_ctrl) begin
      en_d   = bus.mem_wdata[CTRL_EN];
      auto_d = bus.mem_wdata[CTRL_AUTO];
      if (bus.mem_wdata[CTRL_EXP]) exp_d = 1'b0;
    end
    if (hit) exp_d = 1'b1;

    if (wr_cmp) begin
      count_d = '0;
      held_d  = 1'b0;
    end else if (hit) begin
      count_d = auto_q ? 32'h0 : count_q;
      held_d  = !auto_q;
    end else if (run) begin
      count_d = count_q + 32'd1;
      held_d  = 1'b0;
    end
  end

  // Register state; everything returns to reset values asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= '0;
      pend_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      count_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      exp_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      led_q   <= led_d;
      pend_q  <= pend_d;
      lfsr_q  <= lfsr_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      exp_q   <= exp_d;
      held_q  <= held_d;
    end
  end

  // Load data mux: RAM, I/O register, or zero.
  always_comb begin
    status_w = '0;
    status_w[N_SW-1:0]  = sw_sync;
    status_w[16 +: N_BTN] = pend_q;
    bus.rdata = '0;
    if (is_ram) begin
      bus.rdata = bus.ram_rdata;
    end else begin
      case (addr_w)
        ADDR_LED:    bus.rdata = {24'h0, led_q};
        ADDR_STATUS: bus.rdata = status_w;
        ADDR_RNG:    bus.rdata = lfsr_q;
        ADDR_COUNT:  bus.rdata = count_q;
        ADDR_CMP:    bus.rdata = cmp_q;
        ADDR_CTRL:   bus.rdata = {29'h0, exp_q, auto_q, en_q};
        default:     bus.rdata = '0;
      endcase
    end
  end

  assign led_o     = led_q;
  assign timer_irq = exp_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge. Stimulus tasks drive one bus cycle each and
// push the expected observation into a scoreboard queue; a negedge monitor pops
// and compares whenever a cycle is marked for checking.
module tb_mmio_bridge;
  import gt_mmio_pkg::*;

  typedef enum int {S_NONE, S_RDATA, S_RAMWE, S_LED, S_IRQ} obs_e;
  typedef struct {
    obs_e        sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  localparam logic [31:0] IDLE = 32'h0000_2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw  = '0;
  logic [3:0] btn = '0;
  logic [7:0] led;
  logic       irq;

  mmio_bridge_if bus();

  mmio_bridge #(
    .RAM_WORDS(256),
    .LFSR_SEED(32'hACE1_2024),
    .N_BTN    (4),
    .N_SW     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sw_i     (sw),
    .btn_i    (btn),
    .led_o    (led),
    .timer_irq(irq)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  logic        chk_v = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  // Monitor: compare the observation selected by the oldest expectation.
  always @(negedge clk) begin
    if (chk_v) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: check requested with no expectation queued");
      end else begin
        mon_e = sb.pop_front();
        case (mon_e.sel)
          S_RDATA: mon_act = bus.rdata;
          S_RAMWE: mon_act = {31'h0, bus.ram_we};
          S_LED:   mon_act = {24'h0, led};
          S_IRQ:   mon_act = {31'h0, irq};
          default: mon_act = 32'hXXXX_XXXX;
        endcase
        if (mon_act !== mon_e.val) begin
          n_err++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", mon_e.name, mon_act, mon_e.val);
        end
      end
    end
  end

  task automatic cyc(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                     input obs_e sel, input logic [31:0] val, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_we    = we;
    chk_v         = (sel != S_NONE);
    if (sel != S_NONE) begin
      e.sel  = sel;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] val, input string name);
    cyc(addr, 32'h0, 1'b0, S_RDATA, val, name);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    cyc(addr, data, 1'b1, S_NONE, 32'h0, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(IDLE, 32'h0, 1'b0, S_NONE, 32'h0, "");
  endtask

  function automatic logic [31:0] rng_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] model;
    bus.mem_addr  = IDLE;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.ram_rdata = 32'hDEAD_BEEF;

    // Reset state while rst is held.
    rd(ADDR_RNG, 32'hACE1_2024, "rst_rng");
    cyc(IDLE, 0, 1'b0, S_LED, 32'h0, "rst_led");
    cyc(IDLE, 0, 1'b0, S_IRQ, 32'h0, "rst_irq");
    rd(ADDR_COUNT,  32'h0,         "rst_count");
    rd(ADDR_CMP,    32'hFFFF_FFFF, "rst_cmp");
    rd(ADDR_CTRL,   32'h0,         "rst_ctrl");
    rd(ADDR_STATUS, 32'h0,         "rst_status");
    rd(ADDR_RNG,    32'hACE1_2024, "rng_at_release");
    #2 rst = 1'b0;

    // RNG stepping, zero-seed reload and explicit seed.
    rd(ADDR_RNG, 32'h5670_9012, "rng_step1");
    rd(ADDR_RNG, 32'h2B38_4809, "rng_step2");
    rd(ADDR_RNG, 32'h95BC_2407, "rng_step3_tap");
    wr(ADDR_RNG, 32'h0);
    rd(ADDR_RNG, 32'hACE1_2024, "rng_zero_reload");
    rd(ADDR_RNG, 32'h5670_9012, "rng_after_reload");
    wr(ADDR_RNG, 32'h1);
    rd(ADDR_RNG, 32'h0000_0001, "rng_seed_one");
    rd(ADDR_RNG, 32'h8020_0003, "rng_from_one");

    // RAM passthrough vs I/O decode.
    cyc(32'h0000_0008, 32'h5A, 1'b1, S_RAMWE, 32'h1, "ram_we_store");
    rd(32'h0000_0008, 32'hDEAD_BEEF, "ram_read");
    rd(32'h0000_03FC, 32'hDEAD_BEEF, "ram_last_word");
    rd(32'h0000_0400, 32'h0,         "ram_past_end_read");
    cyc(32'h0000_0400, 32'h1, 1'b1, S_RAMWE, 32'h0, "ram_we_past_end");
    cyc(ADDR_LED, 32'h3C, 1'b1, S_RAMWE, 32'h0, "ram_we_io_store");
    cyc(IDLE, 0, 1'b0, S_LED, 32'h3C, "led_after_store");
    rd(ADDR_LED, 32'h3C, "led_read");
    wr(ADDR_LED, 32'hABCD_12A5);
    rd(ADDR_LED, 32'hA5, "led_low_byte");
    wr(IDLE, 32'h77);
    rd(IDLE, 32'h0, "unmapped_read");
    cyc(IDLE, 0, 1'b0, S_LED, 32'hA5, "led_unmapped_write");
    rd(ADDR_BTN_CLR, 32'h0, "btn_clr_reads_zero");
    rd(32'h0000_101C, 32'h0, "io_hole_read");

    // Switch synchroniser: visible after two edges.
    rd(ADDR_STATUS, 32'h0, "sw_edge0");
    sw = 8'h5A;
    rd(ADDR_STATUS, 32'h0,  "sw_edge1");
    rd(ADDR_STATUS, 32'h5A, "sw_edge2");

    // Button rise -> PENDING after three edges, hold, clear.
    rd(ADDR_STATUS, 32'h5A, "btn_edge0");
    btn = 4'b0100;
    rd(ADDR_STATUS, 32'h5A,        "btn_edge1");
    rd(ADDR_STATUS, 32'h5A,        "btn_edge2");
    rd(ADDR_STATUS, 32'h0004_005A, "btn_pending");
    idle(3);
    rd(ADDR_STATUS, 32'h0004_005A, "btn_held");
    wr(ADDR_BTN_CLR, 32'h4);
    rd(ADDR_STATUS, 32'h5A, "btn_cleared");
    rd(ADDR_STATUS, 32'h5A, "btn_no_reedge");
    btn = 4'b0000;
    idle(3);
    btn = 4'b0100;
    idle(1);
    wr(ADDR_BTN_CLR, 32'h4);
    rd(ADDR_STATUS, 32'h0004_005A, "btn_set_beats_clear");

    // Timer one-shot.
    wr(ADDR_CMP, 32'h5);
    wr(ADDR_CTRL, 32'h1);
    rd(ADDR_COUNT, 32'h0, "tmr_start");
    idle(4);
    cyc(IDLE, 0, 1'b0, S_IRQ, 32'h0, "irq_before_match");
    cyc(IDLE, 0, 1'b0, S_IRQ, 32'h1, "irq_on_match");
    rd(ADDR_COUNT, 32'h5, "count_hold_a");
    rd(ADDR_CTRL,  32'h5, "ctrl_expired");
    rd(ADDR_COUNT, 32'h5, "count_hold_b");
    wr(ADDR_CTRL, 32'h4);
    cyc(IDLE, 0, 1'b0, S_IRQ, 32'h0, "irq_cleared");
    wr(ADDR_CTRL, 32'h5);
    rd(ADDR_COUNT, 32'h5, "resume_5");
    rd(ADDR_COUNT, 32'h6, "resume_6");
    rd(ADDR_COUNT, 32'h7, "resume_7");
    rd(ADDR_CTRL,  32'h1, "resume_ctrl");

    // Timer auto-reload.
    wr(ADDR_CTRL, 32'h3);
    wr(ADDR_CMP, 32'h3);
    rd(ADDR_COUNT, 32'h0, "auto_c0");
    rd(ADDR_COUNT, 32'h1, "auto_c1");
    rd(ADDR_COUNT, 32'h2, "auto_c2");
    rd(ADDR_COUNT, 32'h3, "auto_c3");
    rd(ADDR_COUNT, 32'h0, "auto_wrap0");
    rd(ADDR_COUNT, 32'h1, "auto_wrap1");
    rd(ADDR_CTRL,  32'h7, "auto_expired");
    cyc(IDLE, 0, 1'b0, S_IRQ, 32'h1, "irq_auto_held");
    wr(ADDR_CTRL, 32'h7);
    rd(ADDR_CTRL, 32'h3, "auto_exp_cleared");
    idle(1);
    wr(ADDR_CTRL, 32'h7);
    rd(ADDR_CTRL, 32'h7, "exp_set_beats_clear");
    wr(ADDR_CMP, 32'h0);
    wr(ADDR_CTRL, 32'h7);
    rd(ADDR_CTRL,  32'h7, "cmp0_exp_every_cycle");
    rd(ADDR_COUNT, 32'h0, "cmp0_count_a");
    rd(ADDR_COUNT, 32'h0, "cmp0_count_b");

    // Asynchronous reset mid-cycle.
    cyc(IDLE, 0, 1'b0, S_LED, 32'h0, "async_rst_led");
    #1 rst = 1'b1;
    cyc(IDLE, 0, 1'b0, S_IRQ, 32'h0, "async_rst_irq");
    rd(ADDR_RNG,    32'hACE1_2024, "async_rst_rng");
    rd(ADDR_CTRL,   32'h0,         "async_rst_ctrl");
    rd(ADDR_CMP,    32'hFFFF_FFFF, "async_rst_cmp");
    rd(ADDR_COUNT,  32'h0,         "async_rst_count");
    rd(ADDR_STATUS, 32'h0,         "async_rst_status");
    rd(ADDR_RNG,    32'hACE1_2024, "rng_release2");
    #2 rst = 1'b0;

    // RNG walk: matches the Galois recurrence and never reads zero.
    wr(ADDR_RNG, 32'h1);
    model = 32'h1;
    for (int i = 0; i < 1000; i++) begin
      rd(ADDR_RNG, model, "rng_walk");
      model = rng_step(model);
    end

    idle(2);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d expectations unchecked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
